// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path.
//  - Width localparams for prescale, edge counter and bit counter.
//  - Frame lengths with and without a parity bit, and the start-bit index.
//  - maj3: 2-of-3 majority used by the mid-bit sampler.
package uart_rx_pkg;

    localparam int PRESCALE_WIDTH  = 6;
    localparam int EDGE_CNT_WIDTH  = 6;
    localparam int BIT_CNT_WIDTH   = 4;

    localparam int FRAME_LEN_NOPAR = 10;
    localparam int FRAME_LEN_PAR   = 11;
    localparam int START_BIT_IDX   = 1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler_if.sv
// Bundle between the RX FSM (master) and the oversampling front end (slave).
//  master drives : RX_IN, enable, dat_samp_en, PAR_EN, prescale
//  master reads  : edge_cnt, bit_cnt, sampled_bit, samp_valid
interface uart_rx_sampler_if
    import uart_rx_pkg::*;
#(
    parameter int prescale_width = PRESCALE_WIDTH,
    parameter int edge_cnt_width = EDGE_CNT_WIDTH,
    parameter int bit_cnt_width  = BIT_CNT_WIDTH
);
    logic                      RX_IN;
    logic                      enable;
    logic                      dat_samp_en;
    logic                      PAR_EN;
    logic [prescale_width-1:0] prescale;
    logic [edge_cnt_width-1:0] edge_cnt;
    logic [bit_cnt_width-1:0]  bit_cnt;
    logic                      sampled_bit;
    logic                      samp_valid;

    modport master (
        output RX_IN, enable, dat_samp_en, PAR_EN, prescale,
        input  edge_cnt, bit_cnt, sampled_bit, samp_valid
    );

    modport slave (
        input  RX_IN, enable, dat_samp_en, PAR_EN, prescale,
        output edge_cnt, bit_cnt, sampled_bit, samp_valid
    );
endinterface

// File: rtl/uart_rx_edge_bit_counter.sv
// Edge/bit counters of the oversampling front end.
//  CLK, RST       clock, async active-low reset
//  enable         counters run while high, reload to 1/1 while low
//  PAR_EN         selects 11-bit (parity) or 10-bit frame length
//  prescale       oversampling ratio
//  edge_cnt       edge index inside the current bit, 1..prescale
//  bit_cnt        bit index inside the frame, 1..frame length
module uart_rx_edge_bit_counter
    import uart_rx_pkg::*;
#(
    parameter int prescale_width = PRESCALE_WIDTH,
    parameter int edge_cnt_width = EDGE_CNT_WIDTH,
    parameter int bit_cnt_width  = BIT_CNT_WIDTH
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      enable,
    input  logic                      PAR_EN,
    input  logic [prescale_width-1:0] prescale,
    output logic [edge_cnt_width-1:0] edge_cnt,
    output logic [bit_cnt_width-1:0]  bit_cnt
);

    localparam logic [edge_cnt_width-1:0] EDGE_ONE  = edge_cnt_width'(1);
    localparam logic [bit_cnt_width-1:0]  BIT_START = bit_cnt_width'(START_BIT_IDX);
    localparam logic [bit_cnt_width-1:0]  BIT_ONE   = bit_cnt_width'(1);

    logic [edge_cnt_width-1:0] prescale_ext;
    logic [bit_cnt_width-1:0]  frame_len;
    logic                      bit_end;

    assign prescale_ext = edge_cnt_width'(prescale);
    assign frame_len    = PAR_EN ? bit_cnt_width'(FRAME_LEN_PAR)
                                 : bit_cnt_width'(FRAME_LEN_NOPAR);
    // >= rather than == so a prescale lowered mid-frame wraps on the next clock
    assign bit_end      = (edge_cnt >= prescale_ext);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (!enable) begin
            edge_cnt <= EDGE_ONE;
            bit_cnt  <= BIT_START;
        end else if (bit_end) begin
            edge_cnt <= EDGE_ONE;
            // wrapping at the frame end lets back-to-back frames run with enable held
            bit_cnt  <= (bit_cnt == frame_len) ? BIT_START : bit_cnt + BIT_ONE;
        end else begin
            edge_cnt <= edge_cnt + EDGE_ONE;
        end
    end

endmodule

// File: rtl/uart_rx_sampler.sv
// Oversampling front end of the UART receiver.
//  CLK, RST   clock, async active-low reset
//  bus        uart_rx_sampler_if.slave
//    RX_IN, enable, dat_samp_en, PAR_EN, prescale from the RX FSM
//    edge_cnt, bit_cnt       counters from uart_rx_edge_bit_counter
//    sampled_bit             majority of three mid-bit samples of RX_IN
//    samp_valid              one-cycle pulse when sampled_bit was updated
module uart_rx_sampler
    import uart_rx_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    uart_rx_sampler_if.slave bus
);

    logic [EDGE_CNT_WIDTH-1:0] mid;
    logic [EDGE_CNT_WIDTH-1:0] mid_m1;
    logic [EDGE_CNT_WIDTH-1:0] mid_p1;
    logic                      s0;
    logic                      s1;

    uart_rx_edge_bit_counter #(
        .prescale_width (PRESCALE_WIDTH),
        .edge_cnt_width (EDGE_CNT_WIDTH),
        .bit_cnt_width  (BIT_CNT_WIDTH)
    ) u_counter (
        .CLK      (CLK),
        .RST      (RST),
        .enable   (bus.enable),
        .PAR_EN   (bus.PAR_EN),
        .prescale (bus.prescale),
        .edge_cnt (bus.edge_cnt),
        .bit_cnt  (bus.bit_cnt)
    );

    assign mid    = EDGE_CNT_WIDTH'(bus.prescale >> 1);
    assign mid_m1 = mid - EDGE_CNT_WIDTH'(1);
    assign mid_p1 = mid + EDGE_CNT_WIDTH'(1);

    // The third sample is taken straight from RX_IN in the voting cycle,
    // so only the first two need storage.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s0              <= 1'b1;
            s1              <= 1'b1;
            bus.sampled_bit <= 1'b1;
            bus.samp_valid  <= 1'b0;
        end else begin
            bus.samp_valid <= 1'b0;
            if (!bus.enable) begin
                // start-glitch abort: forget partial samples, keep the last vote
                s0 <= 1'b1;
                s1 <= 1'b1;
            end else if (bus.dat_samp_en) begin
                if (bus.edge_cnt == mid_m1) s0 <= bus.RX_IN;
                if (bus.edge_cnt == mid)    s1 <= bus.RX_IN;
                if (bus.edge_cnt == mid_p1) begin
                    bus.sampled_bit <= maj3(s0, s1, bus.RX_IN);
                    bus.samp_valid  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_sampler.sv
module tb_uart_rx_sampler;
    import uart_rx_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    bit   chk_en;

    uart_rx_sampler_if bus ();

    uart_rx_sampler dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: position in the frame follows from the number of
    // enabled clocks since enable rose; votes follow the mid-bit rule.
    int   m_k;
    int   m_edge, m_bit;
    logic m_sb, m_vld, m_s0, m_s1;
    int   m_p, m_fl, m_mid, m_cur;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k = 0; m_edge = 0; m_bit = 0;
            m_sb = 1'b1; m_vld = 1'b0; m_s0 = 1'b1; m_s1 = 1'b1;
        end else begin
            m_p   = int'(bus.prescale);
            m_fl  = bus.PAR_EN ? 11 : 10;
            m_mid = m_p / 2;
            m_cur = m_edge;
            m_vld = 1'b0;
            if (!bus.enable) begin
                m_k = 0; m_s0 = 1'b1; m_s1 = 1'b1;
            end else begin
                m_k++;
                if (bus.dat_samp_en) begin
                    if (m_cur == m_mid - 1) m_s0 = bus.RX_IN;
                    if (m_cur == m_mid)     m_s1 = bus.RX_IN;
                    if (m_cur == m_mid + 1) begin
                        m_sb  = (int'(m_s0) + int'(m_s1) + int'(bus.RX_IN)) >= 2;
                        m_vld = 1'b1;
                    end
                end
            end
            m_edge = (m_k % m_p) + 1;
            m_bit  = ((m_k / m_p) % m_fl) + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("edge_cnt",    int'(bus.edge_cnt),    m_edge);
            chk("bit_cnt",     int'(bus.bit_cnt),     m_bit);
            chk("sampled_bit", int'(bus.sampled_bit), int'(m_sb));
            chk("samp_valid",  int'(bus.samp_valid),  int'(m_vld));
        end
    end

    // Collector of vote results for the literal checks
    logic got[$];
    int   got_edge[$];
    int   max_bit;
    always @(negedge clk) begin
        if (bus.samp_valid) begin
            got.push_back(bus.sampled_bit);
            got_edge.push_back(int'(bus.edge_cnt));
        end
        if (int'(bus.bit_cnt) > max_bit) max_bit = int'(bus.bit_cnt);
    end

    task automatic drive(input logic en, input logic dse, input logic rx);
        @(negedge clk);
        bus.enable      = en;
        bus.dat_samp_en = dse;
        bus.RX_IN       = rx;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b1);
    endtask

    task automatic clear_got();
        got.delete();
        got_edge.delete();
        max_bit = 0;
    endtask

    function automatic logic [15:0] pack(input int first, input int n);
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < n; i++)
            if (first + i < got.size()) v[i] = got[first + i];
        return v;
    endfunction

    // skip: bit index sampled with dat_samp_en low; g1/g2: edges of bit 2 that are inverted
    task automatic send_frame(input logic [7:0] d, input int skip, input int g1, input int g2);
        int   p;
        int   fl;
        logic val;
        logic rx;
        p  = int'(bus.prescale);
        fl = bus.PAR_EN ? 11 : 10;
        for (int b = 1; b <= fl; b++) begin
            if (b == 1)                     val = 1'b0;
            else if (b <= 9)                val = d[b-2];
            else if (b == 10 && bus.PAR_EN) val = ^d;
            else                            val = 1'b1;
            for (int j = 1; j <= p; j++) begin
                rx = val;
                if (b == 2 && (j == g1 || j == g2)) rx = ~val;
                drive(1'b1, (b != skip), rx);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    logic [15:0] v;
    bit          edges_ok;

    initial begin
        n_checks = 0; n_fail = 0; chk_en = 0; max_bit = 0;
        rst_n = 1'b0;
        bus.RX_IN = 1'b1; bus.enable = 1'b0; bus.dat_samp_en = 1'b0;
        bus.PAR_EN = 1'b0; bus.prescale = 6'd8;
        #23;
        chk("reset_edge_cnt",    int'(bus.edge_cnt),    0);
        chk("reset_bit_cnt",     int'(bus.bit_cnt),     0);
        chk("reset_sampled_bit", int'(bus.sampled_bit), 1);
        chk("reset_samp_valid",  int'(bus.samp_valid),  0);
        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1;
        idle(3);

        // 1: prescale 8, no parity, 0xA5, then one extra enabled cycle
        clear_got();
        send_frame(8'hA5, 0, 0, 0);
        drive(1'b1, 1'b0, 1'b1);
        chk("t1_wrap_edge_cnt", int'(bus.edge_cnt), 1);
        chk("t1_wrap_bit_cnt",  int'(bus.bit_cnt),  1);
        chk("t1_max_bit_cnt",   max_bit, 10);
        chk("t1_pulses",        got.size(), 10);
        v = pack(0, 10);
        chk("t1_frame_bits",    int'(v), 'h34A);
        edges_ok = 1;
        foreach (got_edge[i]) if (got_edge[i] != 6) edges_ok = 0;
        chk("t1_pulse_at_edge6", int'(edges_ok), 1);
        idle(3);

        // 2: prescale 16, glitches on data bit 0 (a 1)
        bus.prescale = 6'd16;
        idle(1);
        clear_got();
        send_frame(8'hFF, 0, 8, 0);
        chk("t2_single_glitch", int'(got.size() > 1 ? got[1] : 1'bx), 1);
        idle(2);
        clear_got();
        send_frame(8'hFF, 0, 7, 8);
        chk("t2_double_glitch", int'(got.size() > 1 ? got[1] : 1'bx), 0);
        idle(3);

        // 3: parity frames back-to-back
        bus.prescale = 6'd8;
        bus.PAR_EN   = 1'b1;
        idle(1);
        clear_got();
        send_frame(8'h3C, 0, 0, 0);
        send_frame(8'hC3, 0, 0, 0);
        chk("t3_max_bit_cnt", max_bit, 11);
        chk("t3_pulses",      got.size(), 22);
        v = pack(0, 11);
        chk("t3_frame1_bits", int'(v), 'h478);
        v = pack(11, 11);
        chk("t3_frame2_bits", int'(v), 'h586);
        idle(3);
        bus.PAR_EN = 1'b0;
        idle(1);

        // 4: enable dropped at bit 1, edge 5
        clear_got();
        repeat (4) drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        chk("t4_edge_before_abort", int'(bus.edge_cnt), 5);
        drive(1'b0, 1'b0, 1'b1);
        chk("t4_edge_after_abort", int'(bus.edge_cnt),   1);
        chk("t4_bit_after_abort",  int'(bus.bit_cnt),    1);
        chk("t4_no_valid",         int'(bus.samp_valid), 0);
        idle(2);
        chk("t4_no_pulses",        got.size(), 0);

        // 5: asynchronous reset in bit 4
        repeat (26) drive(1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        chk("t5_bit_before_reset", int'(bus.bit_cnt), 4);
        rst_n = 1'b0;
        #1;
        chk("t5_edge_cnt",    int'(bus.edge_cnt),    0);
        chk("t5_bit_cnt",     int'(bus.bit_cnt),     0);
        chk("t5_sampled_bit", int'(bus.sampled_bit), 1);
        chk("t5_samp_valid",  int'(bus.samp_valid),  0);
        idle(2);
        rst_n = 1'b1;
        idle(2);

        // 6: prescale 32, data bit 4 not sampled
        bus.prescale = 6'd32;
        idle(1);
        clear_got();
        send_frame(8'h0F, 6, 0, 0);
        chk("t6_pulses",     got.size(), 9);
        v = pack(0, 9);
        chk("t6_frame_bits", int'(v), 'h11E);
        idle(3);

        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
